cpu_bus_responder: RTL and testbench

Memory-mapped bus target answering CPU bus cycles (the `o_bus_clk`/`o_bus_we`/`o_bus_addr`/`o_bus_data` strobes in, `i_bus_data`/`i_bus_data_ready` back to the CPU). It decodes a 64-byte window, holds a bank of sixteen 32-bit registers, inserts a fixed number of wait states, and acknowledges every hit cycle with a ready pulse held until the strobe drops. It sits beside the CPU as the template for all on-chip peripherals.

---
 rtl/cpu_bus_pkg.sv | 20 ++
 rtl/bus_resp_regfile.sv | 60 ++++++
 rtl/cpu_bus_responder.sv | 152 +++++++++++++++
 tb/tb_cpu_bus_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg
// Shared widths, register-bank geometry and the responder state encoding
// for the CPU bus target template.
package cpu_bus_pkg;

  localparam int BUS_W     = 32;
  localparam int REG_COUNT = 16;
  localparam int IDX_W     = 4;

  // Register index that becomes a free-running counter in timer builds.
  localparam logic [IDX_W-1:0] TIMER_IDX = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } bus_resp_state_t;

endpackage

// File: rtl/bus_resp_regfile.sv
// bus_resp_regfile
// Sixteen 32-bit registers with one write port and one asynchronous read
// port, plus a continuous tap of register 0.
//
// Build option: BUS_RESP_TIMER_EN
//   defined   - register 15 counts up every clock (wrapping). A write to it
//               loads the written value and skips that cycle's increment.
//   undefined - register 15 is an ordinary read/write register.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset, clears every register
//   wr_en    write strobe (one cycle)
//   wr_idx   write register index
//   wr_data  write data
//   rd_idx   read register index
//   rd_data  register[rd_idx]
//   reg0     register 0, continuously
module bus_resp_regfile
  import cpu_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [BUS_W-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [BUS_W-1:0] rd_data,
  output logic [BUS_W-1:0] reg0
);

`ifdef BUS_RESP_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic [BUS_W-1:0] regs [REG_COUNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          regs[i] <= wr_data;
        end else if (TIMER_EN && (IDX_W'(i) == TIMER_IDX)) begin
          // A write to the timer takes priority over the increment.
          regs[i] <= regs[i] + 32'd1;
        end
      end
    end
  end

  assign rd_data = regs[rd_idx];
  assign reg0    = regs[0];

endmodule

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder
// Memory-mapped bus target for a 64-byte window. Decodes a CPU bus cycle on
// the rising edge of the strobe, inserts WAIT_STATES clocks, performs the
// register access, then holds ready (and read data) until the strobe drops.
//
// Build option: BUS_RESP_TIMER_EN (see bus_resp_regfile) turns register 15
// into a free-running counter.
//
// Parameters:
//   BASE_ADDR    window base, bits [5:0] ignored
//   WAIT_STATES  extra clocks before ready, 0..15
//
// Ports:
//   i_clk             system clock (shared with the CPU)
//   i_rst             synchronous active-high reset
//   i_bus_clk         CPU bus strobe
//   i_bus_we          1 = write cycle
//   i_bus_addr        byte address; [5:2] selects the register
//   i_bus_data        write data
//   o_bus_data        read data, held through HOLD, cleared on exit
//   o_bus_data_ready  cycle acknowledge
//   o_ctrl            live value of register 0
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a strobe rising edge that hits the window
// WAIT  | counting down wait states
// RESP  | one cycle: perform write or capture read data, raise ready
// HOLD  | ready held until the strobe is sampled low
module cpu_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_bus_clk,
  input  logic             i_bus_we,
  input  logic [31:0]      i_bus_addr,
  input  logic [BUS_W-1:0] i_bus_data,
  output logic [BUS_W-1:0] o_bus_data,
  output logic             o_bus_data_ready,
  output logic [BUS_W-1:0] o_ctrl
);

  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  bus_resp_state_t  state;
  bus_resp_state_t  state_next;
  logic             bus_clk_q;
  logic [3:0]       wait_cnt;
  logic [IDX_W-1:0] idx_q;
  logic             we_q;
  logic [BUS_W-1:0] wdata_q;

  logic             hit;
  logic             start;
  logic             rf_we;
  logic [BUS_W-1:0] rf_rdata;

  logic             unused_addr_bits;
  assign unused_addr_bits = ^i_bus_addr[1:0];

  assign hit   = (i_bus_addr[31:6] == BASE_ADDR[31:6]);
  assign start = i_bus_clk && !bus_clk_q && hit;

  always_comb begin
    state_next = state;
    rf_we      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        rf_we      = we_q;
        state_next = HOLD;
      end
      HOLD: begin
        if (!i_bus_clk) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      // Treat the strobe as already high so a strobe held across reset
      // release is not mistaken for a new cycle.
      bus_clk_q        <= 1'b1;
      wait_cnt         <= 4'd0;
      idx_q            <= '0;
      we_q             <= 1'b0;
      wdata_q          <= '0;
      o_bus_data       <= '0;
      o_bus_data_ready <= 1'b0;
    end else begin
      state     <= state_next;
      bus_clk_q <= i_bus_clk;
      case (state)
        IDLE: begin
          if (start) begin
            idx_q    <= i_bus_addr[5:2];
            we_q     <= i_bus_we;
            wdata_q  <= i_bus_data;
            wait_cnt <= CNT_INIT;
          end
        end
        WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          o_bus_data_ready <= 1'b1;
          if (!we_q) begin
            o_bus_data <= rf_rdata;
          end
        end
        HOLD: begin
          if (!i_bus_clk) begin
            o_bus_data_ready <= 1'b0;
            o_bus_data       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  bus_resp_regfile u_regfile (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (rf_we),
    .wr_idx  (idx_q),
    .wr_data (wdata_q),
    .rd_idx  (idx_q),
    .rd_data (rf_rdata),
    .reg0    (o_ctrl)
  );

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder
// Two responders share one bus: dut1 with WAIT_STATES=1 and dut0 with
// WAIT_STATES=0. Cycle c is the state after the c-th rising clock edge
// counted from the edge that first samples the strobe high (c=0). Outputs
// are sampled on the falling edge; bit c of a strobe pattern is the strobe
// value sampled at edge c.
module tb_cpu_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_clk;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] rdata1, rdata0, ctrl1, ctrl0;
  logic        ready1, ready0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_bus_responder #(.BASE_ADDR(32'h0001_0000), .WAIT_STATES(1)) dut1 (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_bus_clk        (bus_clk),
    .i_bus_we         (bus_we),
    .i_bus_addr       (bus_addr),
    .i_bus_data       (bus_wdata),
    .o_bus_data       (rdata1),
    .o_bus_data_ready (ready1),
    .o_ctrl           (ctrl1)
  );

  cpu_bus_responder #(.BASE_ADDR(32'h0001_0000), .WAIT_STATES(0)) dut0 (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_bus_clk        (bus_clk),
    .i_bus_we         (bus_we),
    .i_bus_addr       (bus_addr),
    .i_bus_data       (bus_wdata),
    .o_bus_data       (rdata0),
    .o_bus_data_ready (ready0),
    .o_ctrl           (ctrl0)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] pat;
    logic [15:0] m1;        // expected ready cycles, WAIT_STATES=1
    logic [15:0] m0;        // expected ready cycles, WAIT_STATES=0
    logic [31:0] rd;        // expected o_bus_data at cycle 1+WAIT_STATES
    logic [31:0] ctrl_old;  // o_ctrl before the write lands
    logic [31:0] ctrl_new;  // o_ctrl once the write lands
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [15:0] pat, input logic [15:0] m1, input logic [15:0] m0,
                     input logic [31:0] rd, input logic [31:0] c_old, input logic [31:0] c_new);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.pat = pat;
    v.m1 = m1; v.m0 = m0; v.rd = rd; v.ctrl_old = c_old; v.ctrl_new = c_new;
    vecs.push_back(v);
  endtask

  // Called just after a falling edge; returns just after a falling edge,
  // having spanned exactly 16 rising edges with the strobe left low.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [15:0] pat,
                            output logic [15:0] m1, output logic [15:0] m0,
                            output logic [31:0] d1, output logic [31:0] d0,
                            output logic [31:0] c1_at1, output logic [31:0] c1_at2,
                            output logic [31:0] c0_at1);
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    bus_clk   = pat[0];
    m1 = '0; m0 = '0; d1 = '0; d0 = '0; c1_at1 = '0; c1_at2 = '0; c0_at1 = '0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      @(negedge clk);
      m1[c] = ready1;
      m0[c] = ready0;
      if (c == 1) begin
        d0     = rdata0;
        c1_at1 = ctrl1;
        c0_at1 = ctrl0;
      end
      if (c == 2) begin
        d1     = rdata1;
        c1_at2 = ctrl1;
      end
      bus_clk = (c < 15) ? pat[c+1] : 1'b0;
    end
    bus_clk = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] m1, m0;
    logic [31:0] d1, d0, c1a, c1b, c0;
    logic        any_ready;
    logic [31:0] t1, t2, t3;

    rst = 1'b1; bus_clk = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;

    // Write/read, reg0 tap, miss, byte-offset decode, strobe length corners.
    add(1, 32'h0001_0004, 32'hDEAD_BEEF, 16'h0007, 16'h0004, 16'h0006, 32'h0,         32'h0,  32'h0);
    add(0, 32'h0001_0004, 32'h0,         16'h0007, 16'h0004, 16'h0006, 32'hDEAD_BEEF, 32'h0,  32'h0);
    add(1, 32'h0001_0000, 32'h0000_00A5, 16'h0007, 16'h0004, 16'h0006, 32'h0,         32'h0,  32'hA5);
    add(0, 32'h0001_0040, 32'h0,         16'h0007, 16'h0000, 16'h0000, 32'h0,         32'hA5, 32'hA5);
    add(0, 32'h0001_0007, 32'h0,         16'h0007, 16'h0004, 16'h0006, 32'hDEAD_BEEF, 32'hA5, 32'hA5);
    // strobe high through cycle 5: ready cycles 1..5 (WS=0), 2..5 (WS=1)
    add(0, 32'h0001_0000, 32'h0,         16'h003F, 16'h003C, 16'h003E, 32'hA5,        32'hA5, 32'hA5);
    // one-cycle strobe: exactly one ready cycle
    add(0, 32'h0001_0004, 32'h0,         16'h0001, 16'h0004, 16'h0002, 32'hDEAD_BEEF, 32'hA5, 32'hA5);
    // strobe drops then rises again: ignored in HOLD (WS=1), fresh cycle in IDLE (WS=0)
    add(0, 32'h0001_0004, 32'h0,         16'h0019, 16'h001C, 16'h0012, 32'hDEAD_BEEF, 32'hA5, 32'hA5);
    add(1, 32'h0002_0000, 32'h0000_FFFF, 16'h0007, 16'h0000, 16'h0000, 32'h0,         32'hA5, 32'hA5);
    add(0, 32'h0001_0000, 32'h0,         16'h0007, 16'h0004, 16'h0006, 32'hA5,        32'hA5, 32'hA5);
    add(1, 32'h0001_000B, 32'h0000_0011, 16'h0007, 16'h0004, 16'h0006, 32'h0,         32'hA5, 32'hA5);
    add(0, 32'h0001_0008, 32'h0,         16'h0007, 16'h0004, 16'h0006, 32'h11,        32'hA5, 32'hA5);
`ifndef BUS_RESP_TIMER_EN
    add(1, 32'h0001_003C, 32'h1234_5678, 16'h0007, 16'h0004, 16'h0006, 32'h0,         32'hA5, 32'hA5);
    add(0, 32'h0001_003C, 32'h0,         16'h0007, 16'h0004, 16'h0006, 32'h1234_5678, 32'hA5, 32'hA5);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset ready1", {31'b0, ready1}, 32'h0);
    check("reset ready0", {31'b0, ready0}, 32'h0);
    check("reset data1", rdata1, 32'h0);
    check("reset ctrl1", ctrl1, 32'h0);
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      run_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].pat, m1, m0, d1, d0, c1a, c1b, c0);
      check($sformatf("v%0d ready1 cycles", i), {16'b0, m1}, {16'b0, vecs[i].m1});
      check($sformatf("v%0d ready0 cycles", i), {16'b0, m0}, {16'b0, vecs[i].m0});
      check($sformatf("v%0d data1", i), d1, vecs[i].rd);
      check($sformatf("v%0d data0", i), d0, vecs[i].rd);
      check($sformatf("v%0d ctrl1 c1", i), c1a, vecs[i].ctrl_old);
      check($sformatf("v%0d ctrl1 c2", i), c1b, vecs[i].ctrl_new);
      check($sformatf("v%0d ctrl0 c1", i), c0, vecs[i].ctrl_new);
    end

    // Reset during the wait state of a write to index 3, strobe held high
    // across reset release.
    bus_we = 1'b1; bus_addr = 32'h0001_000C; bus_wdata = 32'h0000_0033; bus_clk = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midreset ready1", {31'b0, ready1}, 32'h0);
    check("midreset ready0", {31'b0, ready0}, 32'h0);
    check("midreset ctrl1", ctrl1, 32'h0);
    any_ready = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      any_ready = any_ready | ready1 | ready0;
    end
    check("no ready with strobe held over reset", {31'b0, any_ready}, 32'h0);
    bus_clk = 1'b0;
    repeat (2) @(negedge clk);

    run_access(0, 32'h0001_000C, 32'h0, 16'h0007, m1, m0, d1, d0, c1a, c1b, c0);
    check("post-reset ready1 cycles", {16'b0, m1}, 32'h0004);
    check("post-reset ready0 cycles", {16'b0, m0}, 32'h0006);
    check("discarded write idx3 data1", d1, 32'h0);
    check("discarded write idx3 data0", d0, 32'h0);
    run_access(0, 32'h0001_0004, 32'h0, 16'h0007, m1, m0, d1, d0, c1a, c1b, c0);
    check("reset cleared idx1", d1, 32'h0);

`ifdef BUS_RESP_TIMER_EN
    // Loaded value FFFF_FFFE; each access spans 16 edges, so the first read
    // sees 15 increments past the load (wrapping through 0).
    run_access(1, 32'h0001_003C, 32'hFFFF_FFFE, 16'h0007, m1, m0, d1, d0, c1a, c1b, c0);
    run_access(0, 32'h0001_003C, 32'h0, 16'h0007, m1, m0, d1, d0, c1a, c1b, c0);
    t1 = d1;
    check("timer read1 dut1", t1, 32'h0000_000D);
    check("timer read1 dut0", d0, 32'h0000_000D);
    run_access(0, 32'h0001_003C, 32'h0, 16'h0007, m1, m0, d1, d0, c1a, c1b, c0);
    t2 = d1;
    check("timer delta 16", t2 - t1, 32'd16);
    repeat (5) @(negedge clk);
    run_access(0, 32'h0001_003C, 32'h0, 16'h0007, m1, m0, d1, d0, c1a, c1b, c0);
    t3 = d1;
    check("timer delta 21", t3 - t2, 32'd21);
    check("timer read3 dut0", d0, 32'h0000_0032);
`else
    t1 = '0; t2 = '0; t3 = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
